// File: rtl/updown_counter.sv
// Parametrised synchronous up/down counter with wrap/saturate modes,
// parallel load, terminal count and wrap/overflow status.
module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Comparisons run one bit wider so MAX = 2**WIDTH-1 and oversized loads compare cleanly.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_max;
  logic             at_zero;
  logic             event_hit;
  logic [WIDTH-1:0] next_count;

  always_comb begin
    count_ext = {1'b0, count};
    load_ext  = {1'b0, load_val};
    at_max    = (count_ext == MAX_EXT);
    at_zero   = (count == '0);
    tc        = en & (up ? at_max : at_zero);
    event_hit = tc & ~load;
    count_n   = ~count;
  end

  always_comb begin
    next_count = count;
    if (load) begin
      next_count = (load_ext > MAX_EXT) ? MAX_W : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) next_count = (SATURATE != 0) ? count : '0;
        else        next_count = count + ONE_W;
      end else begin
        if (at_zero) next_count = (SATURATE != 0) ? count : MAX_W;
        else         next_count = count - ONE_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= event_hit;
      if (event_hit) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: a wrapping MAX=9 instance and a
// saturating MAX=15 instance, each driven by its own input set.
module tb_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: WIDTH=4, MAX=9, wrap mode
  logic       a_rst, a_clear, a_load, a_en, a_up;
  logic [3:0] a_load_val;
  logic [3:0] a_count, a_count_n;
  logic       a_tc, a_wrap, a_ovf;

  // Instance B: WIDTH=4, MAX=15, saturate mode
  logic       b_rst, b_clear, b_load, b_en, b_up;
  logic [3:0] b_load_val;
  logic [3:0] b_count, b_count_n;
  logic       b_tc, b_wrap, b_ovf;

  updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) dut_a (
    .clk(clk), .rst(a_rst), .clear(a_clear), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up(a_up), .count(a_count), .count_n(a_count_n), .tc(a_tc),
    .wrap(a_wrap), .ovf(a_ovf)
  );

  updown_counter #(.WIDTH(4), .MAX(15), .SATURATE(1)) dut_b (
    .clk(clk), .rst(b_rst), .clear(b_clear), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up(b_up), .count(b_count), .count_n(b_count_n), .tc(b_tc),
    .wrap(b_wrap), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int c, input int w, input int o);
    chk({tag, ".count"}, int'(a_count), c);
    chk({tag, ".wrap"},  int'(a_wrap),  w);
    chk({tag, ".ovf"},   int'(a_ovf),   o);
  endtask

  task automatic chk_b(input string tag, input int c, input int w, input int o);
    chk({tag, ".count"}, int'(b_count), c);
    chk({tag, ".wrap"},  int'(b_wrap),  w);
    chk({tag, ".ovf"},   int'(b_ovf),   o);
  endtask

  initial begin
    a_rst = 1'b1; a_clear = 1'b0; a_load = 1'b0; a_load_val = 4'd0; a_en = 1'b0; a_up = 1'b1;
    b_rst = 1'b1; b_clear = 1'b0; b_load = 1'b0; b_load_val = 4'd0; b_en = 1'b0; b_up = 1'b1;

    // Reset state
    step();
    chk_a("reset", 0, 0, 0);
    chk("reset.count_n", int'(a_count_n), 15);
    chk("reset.tc_idle", int'(a_tc), 0);
    a_en = 1'b1; a_up = 1'b0; #1;
    chk("reset.tc_down", int'(a_tc), 1);
    a_up = 1'b1; #1;
    chk("reset.tc_up", int'(a_tc), 0);

    // Wrap up: 1..9, 0, 1, 2
    a_rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("up%0d.tc", k), int'(a_tc), (k == 10) ? 1 : 0);
      step();
      chk_a($sformatf("up%0d", k), (k <= 9) ? k : k - 10,
            (k == 10) ? 1 : 0, (k >= 10) ? 1 : 0);
    end
    chk("up.count_n", int'(a_count_n), 13);

    // Clear, then wrap down from 0
    a_en = 1'b0; a_clear = 1'b1;
    step();
    chk_a("clear0", 0, 0, 0);
    a_clear = 1'b0; a_en = 1'b1; a_up = 1'b0; #1;
    chk("down.tc", int'(a_tc), 1);
    step(); chk_a("down1", 9, 1, 1);
    step(); chk_a("down2", 8, 0, 1);
    step(); chk_a("down3", 7, 0, 1);

    // Priority rst > clear > load > en
    a_en = 1'b0; a_load = 1'b1; a_load_val = 4'd5;
    step(); chk_a("prio_pre", 5, 0, 1);
    a_rst = 1'b1; a_clear = 1'b1; a_load = 1'b1; a_load_val = 4'd3; a_en = 1'b1; a_up = 1'b1;
    step(); chk_a("prio_rst", 0, 0, 0);
    a_rst = 1'b0;
    step(); chk_a("prio_clear", 0, 0, 0);
    a_clear = 1'b0;
    step(); chk_a("prio_load", 3, 0, 0);
    a_load = 1'b0;
    step(); chk_a("prio_en", 4, 0, 0);

    // Load clamp; tc still asserts while load is high
    a_en = 1'b0; a_load = 1'b1; a_load_val = 4'd13;
    step(); chk_a("clamp", 9, 0, 0);
    a_en = 1'b1; a_up = 1'b1; #1;
    chk("clamp.tc_with_load", int'(a_tc), 1);
    step(); chk_a("clamp_load_no_wrap", 9, 0, 0);
    a_load = 1'b0;
    step(); chk_a("clamp_wrap", 0, 1, 1);
    a_en = 1'b0; a_clear = 1'b1;
    step(); chk_a("clamp_clear", 0, 0, 0);
    a_clear = 1'b0;

    // Reset mid-operation with ovf set
    a_load = 1'b1; a_load_val = 4'd9;
    step(); chk_a("mid_load9", 9, 0, 0);
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    step(); chk_a("mid_wrap", 0, 1, 1);
    a_load = 1'b1; a_load_val = 4'd6; a_en = 1'b0;
    step(); chk_a("mid_load6", 6, 0, 1);
    a_load = 1'b0; a_en = 1'b1;
    step(); chk_a("mid_7", 7, 0, 1);
    a_rst = 1'b1;
    step(); chk_a("mid_rst", 0, 0, 0);
    a_rst = 1'b0;
    step(); chk_a("mid_resume", 1, 0, 0);
    a_en = 1'b0;

    // Saturate mode: load 14, count up 4 times
    b_rst = 1'b0; b_load = 1'b1; b_load_val = 4'd14;
    step(); chk_b("sat_load", 14, 0, 0);
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    step(); chk_b("sat1", 15, 0, 0);
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("sat%0d.tc", k), int'(b_tc), 1);
      step();
      chk_b($sformatf("sat%0d", k), 15, 1, 1);
    end
    b_up = 1'b0; #1;
    chk("sat_down.tc", int'(b_tc), 0);
    step(); chk_b("sat_down", 14, 0, 1);

    // Saturate at zero going down
    b_load = 1'b1; b_load_val = 4'd1;
    step(); chk_b("sat0_load", 1, 0, 1);
    b_load = 1'b0;
    step(); chk_b("sat0_a", 0, 0, 1);
    step(); chk_b("sat0_b", 0, 1, 1);
    b_en = 1'b0;
    step(); chk_b("sat0_idle", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
